uart_cmd_decoder: RTL
=====================

# uart_cmd_decoder

Byte-level command sequencer sitting directly behind the UART receiver. It consumes the receiver's `rcv`/`data` byte strobe and parses a fixed 5-byte frame: SYNC, CMD, ADDR, DATA, CHK. Each valid frame becomes a single register-bus read or write request, held under a req/ack handshake. Checksum errors, unknown commands and inter-byte timeouts return the parser to hunt for SYNC and are flagged with an error pulse and code.

## Interface
- `SYNC`, 8'hA5, frame start byte.
- `CMD_WR`, 8'h57 ('W'), write command code.
- `CMD_RD`, 8'h52 ('R'), read command code.
- `TIMEOUT`, 24'd120000, max clk cycles allowed between bytes of one frame (10 ms at 12 MHz). Legal range 2..2^24-1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `rcv`  in  1  one-cycle byte-available strobe from the UART receiver.
- `data`  in  8  received byte; valid in the cycle `rcv`=1.
- `req`  out  1  bus request; held until `ack`.
- `we`  out  1  1 = write, 0 = read; valid while `req`.
- `addr`  out  8  target address; valid while `req`.
- `wdata`  out  8  write data; valid while `req`.
- `ack`  in  1  bus acknowledge; sampled only while `req`=1.
- `busy`  out  1  1 whenever state is not HUNT.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  1 = bad checksum, 2 = unknown command, 3 = timeout. Holds its value until the next error.
- `drop`  out  1  one-cycle pulse: a byte arrived during EXEC and was discarded.

## Operation
- States: HUNT, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC. All registered (Moore) outputs.
- HUNT: `rcv` with `data`==SYNC → GET_CMD. Any other byte is silently ignored.
- GET_CMD/GET_ADDR/GET_DATA: on `rcv`, latch `data` into the cmd/addr/data registers and advance. Inside a frame, the SYNC value is ordinary data; there is no resync.
- Running sum: 8-bit, modulo 256, of CMD+ADDR+DATA. Cleared when SYNC is accepted.
- GET_CHK on `rcv`:
  - CHK ≠ sum → `err`, code 1, go to HUNT.
  - Else cmd not CMD_WR/CMD_RD → `err`, code 2, go to HUNT.
  - Else → EXEC, with `we`=(cmd==CMD_WR), `addr`/`wdata` loaded from the latched bytes.
- READ frames still carry a DATA byte. It is included in the sum; `wdata` shows it, but it is ignored by the bus.
- EXEC: `req`=1. When `ack`=1 is sampled, go to HUNT next cycle with `req`=0. No timeout applies in EXEC.
- `rcv` during EXEC: byte discarded, `drop` pulses.
- Timeout counter:
  - Cleared in HUNT, in EXEC, and on every accepted `rcv`.
  - Increments each cycle in GET_* states.
  - Counter == TIMEOUT-1 with no `rcv` that cycle → `err`, code 3, go to HUNT.
  - A byte arriving in the same cycle as the timeout wins; no error.
- `ack` while `req`=0 is ignored.

## Timing
- Reset values: state HUNT, `req`=0, `we`=0, `addr`=0, `wdata`=0, `busy`=0, `err`=0, `err_code`=0, `drop`=0, counter 0, sum 0.
- Reset mid-frame or mid-EXEC aborts immediately: `req` drops on the cycle after `rst`, and no error is flagged.
- CHK byte accepted at edge N → `req`=1 from cycle N+1. Latency is 1 clk from the final `rcv`.
- `ack` high at edge M → `req`=0, `busy`=0 from cycle M+1. Minimum EXEC length is 1 cycle (`ack` already high).
- `err` and `drop` are 1 cycle wide and asserted the cycle after the triggering edge. `err_code` updates in the same cycle as `err`.
- A new frame may start on the very first `rcv` after returning to HUNT. Back-to-back frames need no gap.
- `busy` goes to 1 the cycle after SYNC is accepted.

## Test plan
- Write: bytes A5 57 10 3C A3, `ack` tied high → exactly one `req` cycle with `we`=1, `addr`=0x10, `wdata`=0x3C; `err`=0.
- Read with stalled ack: A5 52 20 00 72, `ack` raised 5 cycles after `req` → `req` high for exactly 6 cycles, `we`=0, `addr`=0x20. A byte 0x11 injected during EXEC → `drop` pulse, no state change.
- Checksum error: A5 57 10 3C 00 → `err` pulse, `err_code`=1, no `req`. A following valid write frame is then executed normally.
- Unknown command plus garbage: 00 FF A5 41 00 00 41 → leading bytes ignored, `err` pulse with `err_code`=2, no `req`.
- Timeout (TIMEOUT=100): A5 57, then silence → `err` with `err_code`=3 exactly 100 cycles after the 0x57 strobe. A byte on cycle 99 instead produces no error.
- Reset mid-frame (after A5 57 10) and mid-EXEC → all outputs return to reset values, and a subsequent A5 57 10 3C A3 completes correctly.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns SYNC/CMD/ADDR/DATA/CHK byte frames from the UART receiver into register-bus requests.
// Latency: req rises 1 clk after the CHK byte strobe and falls 1 clk after ack is sampled high.
// Backpressure: the byte stream has no ready; bytes arriving while a request is pending are discarded with a drop pulse.
module uart_cmd_decoder #(
  parameter logic [23:0] TIMEOUT = 24'd120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcv,
  input  logic [7:0] data,
  output logic       req,
  output logic       we,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic       ack,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  output logic       drop
);

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  typedef enum logic [2:0] {
    HUNT     = 3'd0,
    GET_CMD  = 3'd1,
    GET_ADDR = 3'd2,
    GET_DATA = 3'd3,
    GET_CHK  = 3'd4,
    EXEC     = 3'd5
  } state_t;

  state_t      state_q;
  logic [7:0]  cmd_q;
  logic [7:0]  adr_lat_q;
  logic [7:0]  dat_lat_q;
  logic [7:0]  sum_q;
  logic [23:0] cnt_q;
  logic        req_q;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        busy_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic        drop_q;

  logic        in_frame;
  logic        tmo_hit;
  logic [7:0]  sum_d;
  logic [23:0] cnt_d;

  // Inter-byte timeout detection plus next values of the running sum and idle counter
  always_comb begin
    in_frame = (state_q == GET_CMD) || (state_q == GET_ADDR) ||
               (state_q == GET_DATA) || (state_q == GET_CHK);
    // A byte landing on the expiry cycle keeps the frame alive.
    tmo_hit  = in_frame && !rcv && (cnt_q == (TIMEOUT - 24'd1));
    sum_d    = sum_q + data;
    cnt_d    = cnt_q + 24'd1;
  end

  // Frame parser FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      cmd_q      <= 8'h00;
      adr_lat_q  <= 8'h00;
      dat_lat_q  <= 8'h00;
      sum_q      <= 8'h00;
      cnt_q      <= 24'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      drop_q     <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      if (tmo_hit) begin
        state_q    <= HUNT;
        cnt_q      <= 24'd0;
        busy_q     <= 1'b0;
        err_q      <= 1'b1;
        err_code_q <= 2'd3;
      end else begin
        case (state_q)
          HUNT: begin
            cnt_q <= 24'd0;
            if (rcv && (data == SYNC)) begin
              state_q <= GET_CMD;
              sum_q   <= 8'h00;
              busy_q  <= 1'b1;
            end
          end
          GET_CMD: begin
            if (rcv) begin
              cmd_q   <= data;
              sum_q   <= sum_d;
              cnt_q   <= 24'd0;
              state_q <= GET_ADDR;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          GET_ADDR: begin
            if (rcv) begin
              adr_lat_q <= data;
              sum_q     <= sum_d;
              cnt_q     <= 24'd0;
              state_q   <= GET_DATA;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          GET_DATA: begin
            if (rcv) begin
              dat_lat_q <= data;
              sum_q     <= sum_d;
              cnt_q     <= 24'd0;
              state_q   <= GET_CHK;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          GET_CHK: begin
            if (rcv) begin
              cnt_q <= 24'd0;
              if (data != sum_q) begin
                state_q    <= HUNT;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= 2'd1;
              end else if ((cmd_q != CMD_WR) && (cmd_q != CMD_RD)) begin
                state_q    <= HUNT;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= 2'd2;
              end else begin
                state_q <= EXEC;
                req_q   <= 1'b1;
                we_q    <= (cmd_q == CMD_WR);
                addr_q  <= adr_lat_q;
                wdata_q <= dat_lat_q;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          EXEC: begin
            // No timeout while waiting for the bus; any byte here is lost.
            cnt_q <= 24'd0;
            if (rcv) begin
              drop_q <= 1'b1;
            end
            if (ack) begin
              state_q <= HUNT;
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= HUNT;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 24'd0;
          end
        endcase
      end
    end
  end

  assign req      = req_q;
  assign we       = we_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign drop     = drop_q;

endmodule
